// File: rtl/jtframe_joy_serial_pkg.sv
// Shared definitions for the serial joystick reader: FSM states,
// player-word button indices and a counter-width helper.
package jtframe_joy_serial_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SHIFT  = 2'd2
  } joy_state_t;

  // Button positions inside each player word
  localparam int unsigned JOY_RIGHT = 0;
  localparam int unsigned JOY_LEFT  = 1;
  localparam int unsigned JOY_DOWN  = 2;
  localparam int unsigned JOY_UP    = 3;
  localparam int unsigned JOY_B1    = 4;
  localparam int unsigned JOY_B2    = 5;
  localparam int unsigned JOY_B3    = 6;
  localparam int unsigned JOY_B4    = 7;
  localparam int unsigned JOY_START = 8;
  localparam int unsigned JOY_COIN  = 9;

  // Width of a counter covering 0..n-1, never below one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jtframe_joy_serial_tick.sv
// jtframe_joy_tick: free-running divider producing a one-cycle enable
// every CLKDIV clk_sys cycles. Shared by slow serial peripherals.
module jtframe_joy_tick
  import jtframe_joy_serial_pkg::*;
#(
  parameter int CLKDIV = 16
) (
  input  logic clk_sys,
  input  logic rst,
  output logic o_tick
);

  localparam int CW = cnt_w(CLKDIV);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(CLKDIV - 1));
  assign o_tick = w_wrap;

  // Count 0..CLKDIV-1 and wrap
  always_ff @(posedge clk_sys) begin
    if (rst)         r_cnt <= '0;
    else if (w_wrap) r_cnt <= '0;
    else             r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/jtframe_joy_serial.sv
// jtframe_joy_serial: drives a 74HC165-style chain (JOY_LOAD/JOY_CLK),
// deserialises PLAYERS*BITS_PER_PLAYER bits and updates all player
// words together at frame end.
// Optional: JTFRAME_JOY_DEBOUNCE_EN - only latch a frame identical to
// the previous one.
module jtframe_joy_serial
  import jtframe_joy_serial_pkg::*;
#(
  parameter int PLAYERS         = 2,
  parameter int BITS_PER_PLAYER = 12,
  parameter int JOYW            = 32,
  parameter int CLKDIV          = 16,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                    clk_sys,
  input  logic                    rst,
  input  logic                    JOY_DATA,
  output logic                    JOY_CLK,
  output logic                    JOY_LOAD,
  output logic [PLAYERS*JOYW-1:0] joystick,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int TOTAL = PLAYERS * BITS_PER_PLAYER;
  localparam int KW    = cnt_w(TOTAL);

  joy_state_t              r_state, w_state_nxt;
  logic                    r_load, w_load_nxt;
  logic                    r_clk, w_clk_nxt;
  logic [KW-1:0]           r_k, w_k_nxt;
  logic                    w_sample, w_latch, w_accept, w_tick;
  logic [TOTAL-1:0]        r_shadow;
  logic [PLAYERS*JOYW-1:0] r_joy, w_mapped;
  logic                    r_fd;

  jtframe_joy_tick #(.CLKDIV(CLKDIV)) u_tick (
    .clk_sys (clk_sys),
    .rst     (rst),
    .o_tick  (w_tick)
  );

  // State register
  always_ff @(posedge clk_sys) begin
    if (rst) r_state <= ST_LOAD;
    else     r_state <= w_state_nxt;
  end

  // Next-state and registered-output decisions, all gated by tick
  always_comb begin
    w_state_nxt = r_state;
    w_load_nxt  = r_load;
    w_clk_nxt   = r_clk;
    w_k_nxt     = r_k;
    w_sample    = 1'b0;
    w_latch     = 1'b0;
    if (w_tick) begin
      case (r_state)
        ST_LOAD: begin
          w_load_nxt  = 1'b0;
          w_clk_nxt   = 1'b0;
          w_state_nxt = ST_SETTLE;
        end
        ST_SETTLE: begin
          w_load_nxt  = 1'b1;
          w_k_nxt     = '0;
          w_state_nxt = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (!r_clk) begin
            w_sample  = 1'b1;
            w_clk_nxt = 1'b1;
          end else begin
            w_clk_nxt = 1'b0;
            if (r_k == KW'(TOTAL - 1)) begin
              w_latch     = 1'b1;
              w_state_nxt = ST_LOAD;
            end else begin
              w_k_nxt = r_k + KW'(1);
            end
          end
        end
        default: w_state_nxt = ST_LOAD;
      endcase
    end
  end

  // Stream bit k lands in player k/BITS_PER_PLAYER, bit k%BITS_PER_PLAYER
  always_comb begin
    w_mapped = '0;
    for (int unsigned p = 0; p < PLAYERS; p++)
      for (int unsigned b = 0; b < BITS_PER_PLAYER; b++)
        w_mapped[p*JOYW + b] = r_shadow[p*BITS_PER_PLAYER + b];
  end

`ifdef JTFRAME_JOY_DEBOUNCE_EN
  logic [TOTAL-1:0] r_prev;

  // Remember the last completed frame for the stability compare
  always_ff @(posedge clk_sys) begin
    if (rst)          r_prev <= '0;
    else if (w_latch) r_prev <= r_shadow;
  end

  assign w_accept = (r_shadow == r_prev);
`else
  assign w_accept = 1'b1;
`endif

  // Chain controls, shadow capture and frame latch
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_load   <= 1'b1;
      r_clk    <= 1'b0;
      r_k      <= '0;
      r_shadow <= '0;
      r_joy    <= '0;
      r_fd     <= 1'b0;
    end else begin
      r_load <= w_load_nxt;
      r_clk  <= w_clk_nxt;
      r_k    <= w_k_nxt;
      r_fd   <= w_latch & w_accept;
      if (w_sample)             r_shadow[r_k] <= JOY_DATA ^ ACTIVE_LOW;
      if (w_latch && w_accept)  r_joy         <= w_mapped;
    end
  end

  assign JOY_CLK    = r_clk;
  assign JOY_LOAD   = r_load;
  assign joystick   = r_joy;
  assign frame_done = r_fd;
  assign busy       = (r_state != ST_LOAD);

endmodule

// File: tb/tb_jtframe_joy_serial.sv
// Bench for jtframe_joy_serial: default instance (2x12, CLKDIV=16) and a
// 4x8, CLKDIV=2 instance, each fed by a behavioural 74HC165 chain.
module tb_jtframe_joy_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [63:0]  raw_a = '1;
  logic [63:0]  raw_b = '1;
  logic [6:0]   idx_a = '0;
  logic [6:0]   idx_b = '0;
  logic         data_a, data_b;
  logic         jclk_a, jload_a, fd_a, busy_a;
  logic         jclk_b, jload_b, fd_b, busy_b;
  logic [63:0]  joy_a;
  logic [127:0] joy_b;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Chain models: parallel load while JOY_LOAD low, advance on JOY_CLK rise
  always @(negedge jload_a or posedge jclk_a)
    if (!jload_a) idx_a <= '0; else idx_a <= idx_a + 7'd1;
  always @(negedge jload_b or posedge jclk_b)
    if (!jload_b) idx_b <= '0; else idx_b <= idx_b + 7'd1;
  assign data_a = raw_a[idx_a[5:0]];
  assign data_b = raw_b[idx_b[5:0]];

  jtframe_joy_serial u_dut (
    .clk_sys (clk), .rst (rst), .JOY_DATA (data_a),
    .JOY_CLK (jclk_a), .JOY_LOAD (jload_a), .joystick (joy_a),
    .frame_done (fd_a), .busy (busy_a)
  );

  jtframe_joy_serial #(
    .PLAYERS (4), .BITS_PER_PLAYER (8), .JOYW (32), .CLKDIV (2), .ACTIVE_LOW (1'b1)
  ) u_dut4 (
    .clk_sys (clk), .rst (rst), .JOY_DATA (data_b),
    .JOY_CLK (jclk_b), .JOY_LOAD (jload_b), .joystick (joy_b),
    .frame_done (fd_b), .busy (busy_b)
  );

  task automatic wait_fd(input bit sel, input int limit, output int cycles, output bit found);
    found  = 1'b0;
    cycles = 0;
    while (!found && cycles < limit) begin
      @(posedge clk); #1;
      cycles++;
      if ((sel ? fd_b : fd_a) === 1'b1) found = 1'b1;
    end
  endtask

  task automatic run_a(input int n, output int pulses, output int last);
    pulses = 0;
    last   = -1;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (fd_a === 1'b1) begin pulses++; last = i; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (joy_a !== 64'h0) $display("FAIL reset_joy: got %h want %h", joy_a, 64'h0);
    else pass_cnt++;
    total_cnt++;
    if ({jclk_a, jload_a, fd_a, busy_a} !== 4'b0100)
      $display("FAIL reset_ctl {clk,load,fd,busy}: got %b want 0100", {jclk_a, jload_a, fd_a, busy_a});
    else pass_cnt++;
    total_cnt++;
    if ({joy_b, fd_b, jload_b} !== {128'h0, 1'b0, 1'b1})
      $display("FAIL reset_p4: got joy=%h fd=%b load=%b want 0/0/1", joy_b, fd_b, jload_b);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_timing;
    int  low_start = -1;
    int  low_len = 0;
    int  rises = 0;
    int  fd_cyc = -1;
    int  c;
    bit  f;
    bit  prev_clk = 1'b0;
    for (int n = 1; n <= 1000 && fd_cyc < 0; n++) begin
      @(posedge clk); #1;
      if (!jload_a) begin
        if (low_start < 0) low_start = n;
        low_len++;
      end
      if (jclk_a && !prev_clk) rises++;
      prev_clk = jclk_a;
      if (fd_a === 1'b1) fd_cyc = n;
    end
    total_cnt++;
    if (low_start != 16) $display("FAIL load_start: got %0d want 16", low_start); else pass_cnt++;
    total_cnt++;
    if (low_len != 16) $display("FAIL load_len: got %0d want 16", low_len); else pass_cnt++;
    total_cnt++;
    if (rises != 24) $display("FAIL clk_rises: got %0d want 24", rises); else pass_cnt++;
    total_cnt++;
    if (fd_cyc != 800) $display("FAIL first_frame: got %0d want 800", fd_cyc); else pass_cnt++;
    total_cnt++;
    if (joy_a !== 64'h0) $display("FAIL all_released: got %h want 0", joy_a); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (fd_a !== 1'b0) $display("FAIL fd_one_cycle: got %b want 0", fd_a); else pass_cnt++;
    wait_fd(1'b0, 1000, c, f);
    c = c + 1;
    total_cnt++;
    if (!f || c != 800) $display("FAIL frame_period: got %0d found=%0d want 800", c, f); else pass_cnt++;
  endtask

  task automatic test_patterns;
    logic [63:0] praw [5];
    logic [63:0] pexp [5];
    int c;
    bit f;
    praw[0] = ~64'h1;                pexp[0] = 64'h00000000_00000001;
    praw[1] = ~(64'h1 << 12);        pexp[1] = 64'h00000001_00000000;
    praw[2] = ~64'h0000_0000_00A5_C3B1; pexp[2] = 64'h00000A5C_000003B1;
    praw[3] = 64'h0;                 pexp[3] = 64'h00000FFF_00000FFF;
    praw[4] = '1;                    pexp[4] = 64'h0;
    for (int i = 0; i < 5; i++) begin
      raw_a = praw[i];
      wait_fd(1'b0, 1000, c, f);
      total_cnt++;
      if (!f || joy_a !== pexp[i])
        $display("FAIL pattern%0d: got %h found=%0d want %h", i, joy_a, f, pexp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midframe;
    int  c;
    bit  f;
    int  rises = 0;
    bit  prev_clk = 1'b0;
    int  early = 0;
    int  nonzero = 0;
    int  load_at = -1;
    bit  fd_end;
    logic [63:0] joy_end;
    raw_a = 64'h0;
    wait_fd(1'b0, 1000, c, f);
    for (int n = 0; n < 1000 && rises < 11; n++) begin
      @(posedge clk); #1;
      if (jclk_a && !prev_clk) rises++;
      prev_clk = jclk_a;
    end
    total_cnt++;
    if (busy_a !== 1'b1 || rises != 11) $display("FAIL busy_shift: got busy=%b rises=%0d want 1/11", busy_a, rises);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({joy_a, fd_a, jclk_a, jload_a, busy_a} !== {64'h0, 4'b0010})
      $display("FAIL midreset_state: got joy=%h fd=%b clk=%b load=%b busy=%b", joy_a, fd_a, jclk_a, jload_a, busy_a);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    fd_end  = 1'b0;
    joy_end = '0;
    for (int n = 1; n <= 800; n++) begin
      @(posedge clk); #1;
      if (!jload_a && load_at < 0) load_at = n;
      if (n < 800) begin
        if (fd_a !== 1'b0) early++;
        if (joy_a !== 64'h0) nonzero++;
      end else begin
        fd_end  = fd_a;
        joy_end = joy_a;
      end
    end
    total_cnt++;
    if (early != 0 || nonzero != 0) $display("FAIL midreset_quiet: got early_fd=%0d nonzero=%0d want 0/0", early, nonzero);
    else pass_cnt++;
    total_cnt++;
    if (load_at != 16) $display("FAIL midreset_load: got %0d want 16", load_at); else pass_cnt++;
    total_cnt++;
    if (fd_end !== 1'b1 || joy_end !== 64'h00000FFF_00000FFF)
      $display("FAIL midreset_frame: got fd=%b joy=%h want 1/00000fff00000fff", fd_end, joy_end);
    else pass_cnt++;
  endtask

  task automatic test_p4;
    int c;
    bit f;
    wait_fd(1'b1, 300, c, f);
    raw_b = ~64'h0000_0000_A1B2_C3D4;
    wait_fd(1'b1, 300, c, f);
    total_cnt++;
    if (!f || c != 132) $display("FAIL p4_period: got %0d found=%0d want 132", c, f); else pass_cnt++;
    total_cnt++;
    if (joy_b !== 128'h000000A1_000000B2_000000C3_000000D4)
      $display("FAIL p4_words: got %h want 000000a1000000b2000000c3000000d4", joy_b);
    else pass_cnt++;
    raw_b = '1;
    wait_fd(1'b1, 300, c, f);
    total_cnt++;
    if (!f || joy_b !== 128'h0) $display("FAIL p4_release: got %h found=%0d want 0", joy_b, f); else pass_cnt++;
  endtask

  task automatic test_debounce;
    int c, pulses, last;
    bit f;
    wait_fd(1'b0, 1000, c, f);
    total_cnt++;
    if (!f || c != 800 || joy_a !== 64'h0) $display("FAIL db_first: got cyc=%0d found=%0d joy=%h want 800/1/0", c, f, joy_a);
    else pass_cnt++;
    raw_a = ~64'h1;
    run_a(800, pulses, last);
    raw_a = '1;
    total_cnt++;
    if (pulses != 0 || joy_a !== 64'h0) $display("FAIL db_glitch: got pulses=%0d joy=%h want 0/0", pulses, joy_a);
    else pass_cnt++;
    run_a(800, pulses, last);
    total_cnt++;
    if (pulses != 0 || joy_a !== 64'h0) $display("FAIL db_recover: got pulses=%0d joy=%h want 0/0", pulses, joy_a);
    else pass_cnt++;
    run_a(800, pulses, last);
    total_cnt++;
    if (pulses != 1 || last != 800 || joy_a !== 64'h0) $display("FAIL db_stable: got pulses=%0d at=%0d joy=%h want 1/800/0", pulses, last, joy_a);
    else pass_cnt++;
    raw_a = ~64'h1;
    run_a(800, pulses, last);
    total_cnt++;
    if (pulses != 0 || joy_a !== 64'h0) $display("FAIL db_press1: got pulses=%0d joy=%h want 0/0", pulses, joy_a);
    else pass_cnt++;
    run_a(800, pulses, last);
    total_cnt++;
    if (pulses != 1 || last != 800 || joy_a !== 64'h1) $display("FAIL db_press2: got pulses=%0d at=%0d joy=%h want 1/800/1", pulses, last, joy_a);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
`ifdef JTFRAME_JOY_DEBOUNCE_EN
    test_debounce;
`else
    test_load_timing;
    test_patterns;
    test_reset_midframe;
    test_p4;
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
